// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, byte-lane
// masks, the controller state type and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_mask = MASK_B;
      F3_H, F3_HU: size_mask = MASK_H;
      default:     size_mask = MASK_W;
    endcase
  endfunction

  // Byte accesses can never straddle a word; halves only straddle from offset 3.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    is_misaligned = ((funct3 == F3_H || funct3 == F3_HU) && offset == 2'b11) ||
                    (funct3 == F3_W && offset != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed bytes out of a two-word window
// and sign- or zero-extends them according to the width code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [63:0] data,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = 32'(data >> {offset, 3'b000});

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: turns byte-addressed core accesses into
// one or two word-aligned memory transactions and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a memory transaction transfers where mem_valid && mem_ready, with mem_* held
  // stable until then; mem_rvalid is only honoured in WAIT1/WAIT2.

  lsu_state_e  state, next_state;
  logic        lat_we, lat_err;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] rdata_lo, rdata_hi;

  logic        req_legal, req_err, lat_split;
  logic [7:0]  mask_sh;
  logic [63:0] data_sh;
  logic [31:0] word_addr, load_result;

  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: req_legal = 1'b1;
      F3_BU, F3_HU:     req_legal = !req_we;
      default:          req_legal = 1'b0;
    endcase
    req_err = !req_legal || (is_misaligned(req_funct3, req_addr[1:0]) && !MISALIGN_EN);
  end

  assign lat_split = MISALIGN_EN && is_misaligned(lat_f3, lat_addr[1:0]);
  assign mask_sh   = {4'b0000, size_mask(lat_f3)} << lat_addr[1:0];
  assign data_sh   = {32'h0, lat_wdata} << {lat_addr[1:0], 3'b000};
  assign word_addr = {lat_addr[31:2], 2'b00};
  assign dbg_state = state;

  lsu_load_align u_align (
    .funct3 (lat_f3),
    .offset (lat_addr[1:0]),
    .data   ({rdata_hi, rdata_lo}),
    .result (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_byteen = 4'b0000;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = req_err ? RESP : REQ1;
      end
      REQ1: begin
        mem_valid  = 1'b1;
        mem_we     = lat_we;
        mem_addr   = word_addr;
        mem_byteen = mask_sh[3:0];
        mem_wdata  = data_sh[31:0];
        if (mem_ready) next_state = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) next_state = lat_split ? REQ2 : RESP;
      end
      REQ2: begin
        // Second half: the lanes that spilled past the first word boundary.
        mem_valid  = 1'b1;
        mem_we     = lat_we;
        mem_addr   = word_addr + 32'd4;
        mem_byteen = mask_sh[7:4];
        mem_wdata  = data_sh[63:32];
        if (mem_ready) next_state = WAIT2;
      end
      WAIT2: begin
        if (mem_rvalid) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = lat_err;
        resp_rdata = (lat_err || lat_we) ? 32'h0 : load_result;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_f3    <= 3'b000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      rdata_lo  <= 32'h0;
      rdata_hi  <= 32'h0;
    end else begin
      if (req_valid && req_ready) begin
        lat_we    <= req_we;
        lat_err   <= req_err;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        rdata_hi  <= 32'h0;
      end
      if (state == WAIT1 && mem_rvalid) rdata_lo <= mem_rdata;
      if (state == WAIT2 && mem_rvalid) rdata_hi <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory reference model, directed
// corner cases, randomized accesses and a mid-transaction reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  lsu_state_e  dbg_state;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [2:0]  b_req_funct3 = 3'b000;
  logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic        b_mem_valid, b_mem_we;
  logic        b_mem_ready = 1'b0, b_mem_rvalid = 1'b0;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h0;
  logic [3:0]  b_mem_byteen;
  lsu_state_e  b_dbg_state;

  load_store_unit u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  load_store_unit #(.MISALIGN_EN(1'b0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_byteen(b_mem_byteen), .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid),
    .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // byte-addressed memory model; untouched bytes read as a fixed pattern
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tx_t;

  tx_t tx_log[$];
  int  stall_cycles = 0;
  int  stall_cnt = 0;
  bit  rv_pend = 1'b0;
  logic [31:0] rv_data = 32'h0;

  // memory responder: optional stall, then ready; read data one cycle later
  initial begin
    tx_t cur, snap;
    snap = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_pend) begin
        mem_rvalid = 1'b1;
        mem_rdata = rv_data;
        rv_pend = 1'b0;
      end else if (mem_valid && rst_n) begin
        cur = '{we: mem_we, addr: mem_addr, be: mem_byteen, wdata: mem_wdata};
        if (stall_cnt > 0) chk("mem_stable", 96'(cur), 96'(snap));
        else snap = cur;
        if (stall_cnt < stall_cycles) begin
          stall_cnt++;
        end else begin
          mem_ready = 1'b1;
          tx_log.push_back(cur);
          rv_data = rd_word(mem_addr);
          rv_pend = 1'b1;
          stall_cnt = 0;
        end
      end
    end
  end

  function automatic int f3_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit f3_legal(input logic we, input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
    if (f3 == 3'b100 || f3 == 3'b101) return !we;
    return 1'b0;
  endfunction

  logic [31:0] last_rdata;
  logic        last_err;

  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall, input string tag);
    tx_t exp_q[$];
    tx_t t;
    logic [31:0] base, exp_rdata;
    logic exp_err;
    int size, ntx, lat, idx;
    size = f3_size(f3);
    exp_err = !f3_legal(we, f3);
    base = {addr[31:2], 2'b00};
    ntx = (int'(addr[1:0]) + size > 4) ? 2 : 1;
    exp_rdata = 32'h0;
    if (!exp_err) begin
      for (int k = 0; k < ntx; k++) begin
        t.we = we;
        t.addr = base + 32'(4 * k);
        t.be = 4'b0000;
        t.wdata = 32'h0;
        for (int j = 0; j < 4; j++) begin
          idx = 4 * k + j - int'(addr[1:0]);
          if (idx >= 0 && idx < size) t.be[j] = 1'b1;
          if (idx >= 0 && idx < 4) t.wdata[8*j +: 8] = wdata[8*idx +: 8];
        end
        exp_q.push_back(t);
      end
      if (!we) begin
        for (int i = 0; i < size; i++) exp_rdata[8*i +: 8] = rd_byte(addr + 32'(i));
        if (f3 == 3'b000 && exp_rdata[7]) exp_rdata[31:8] = 24'hFFFFFF;
        if (f3 == 3'b001 && exp_rdata[15]) exp_rdata[31:16] = 16'hFFFF;
      end
    end
    tx_log.delete();
    stall_cycles = stall;
    @(negedge clk);
    chk({tag, "_ready"}, 96'(req_ready), 96'(1));
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    last_rdata = resp_rdata;
    last_err = resp_err;
    chk({tag, "_resp_seen"}, 96'(resp_valid), 96'(1));
    chk({tag, "_latency"}, 96'(lat), 96'(exp_err ? 1 : 1 + ntx * (2 + stall)));
    chk({tag, "_err"}, 96'(resp_err), 96'(exp_err));
    chk({tag, "_rdata"}, 96'(resp_rdata), 96'(exp_rdata));
    chk({tag, "_ntx"}, 96'(tx_log.size()), 96'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < tx_log.size(); k++)
      chk({tag, "_tx"}, 96'(tx_log[k]), 96'(exp_q[k]));
    @(negedge clk);
    chk({tag, "_pulse"}, 96'({resp_valid, req_ready}), 96'(2'b01));
    if (we && !exp_err)
      for (int i = 0; i < size; i++) mem[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 96'(req_ready), 96'(1));
    chk({tag, "_state"}, 96'(dbg_state), 96'(IDLE));
    chk({tag, "_mem"}, 96'({mem_valid, mem_we, mem_byteen, mem_addr, mem_wdata}), 96'(0));
    chk({tag, "_resp"}, 96'({resp_valid, resp_err, resp_rdata}), 96'(0));
  endtask

  task automatic strict_err(input logic [2:0] f3, input logic [31:0] addr, input string tag);
    int lat;
    bit saw;
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_funct3 = f3;
    b_req_addr = addr;
    saw = b_mem_valid;
    @(negedge clk);
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_resp_valid && lat < 10) begin
      saw |= b_mem_valid;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 96'(lat), 96'(1));
    chk({tag, "_err"}, 96'({b_resp_err, b_resp_rdata}), 96'({1'b1, 32'h0}));
    chk({tag, "_no_mem"}, 96'(saw), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    int n;
    mem[32'h100] = 8'h7F; mem[32'h101] = 8'hFF; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h7F;
    mem[32'h104] = 8'h44; mem[32'h105] = 8'h33; mem[32'h106] = 8'h22; mem[32'h107] = 8'h11;

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    do_access(1'b0, 3'b000, 32'h100, 32'h0, 0, "lb_100");
    chk("lb_100_be", 96'(tx_log[0].be), 96'(4'b0001));
    chk("lb_100_val", 96'(last_rdata), 96'(32'h0000007F));
    do_access(1'b0, 3'b001, 32'h100, 32'h0, 0, "lh_100");
    chk("lh_100_val", 96'(last_rdata), 96'(32'hFFFFFF7F));
    do_access(1'b0, 3'b101, 32'h100, 32'h0, 0, "lhu_100");
    chk("lhu_100_val", 96'(last_rdata), 96'(32'h0000FF7F));
    do_access(1'b0, 3'b001, 32'h102, 32'h0, 0, "lh_102");
    chk("lh_102_val", 96'(last_rdata), 96'(32'h00007FFF));
    do_access(1'b0, 3'b010, 32'h103, 32'h0, 0, "lw_103");
    chk("lw_103_tx0", 96'({tx_log[0].addr, tx_log[0].be}), 96'({32'h100, 4'b1000}));
    chk("lw_103_tx1", 96'({tx_log[1].addr, tx_log[1].be}), 96'({32'h104, 4'b0111}));
    chk("lw_103_val", 96'(last_rdata), 96'(32'h2233447F));
    do_access(1'b0, 3'b010, 32'h104, 32'h0, 5, "lw_stall");

    do_access(1'b1, 3'b010, 32'h102, 32'hDEADBEEF, 0, "sw_102");
    chk("sw_102_tx0", 96'({tx_log[0].addr, tx_log[0].be, tx_log[0].wdata}),
        96'({32'h100, 4'b1100, 32'hBEEF0000}));
    chk("sw_102_tx1", 96'({tx_log[1].addr, tx_log[1].be, tx_log[1].wdata}),
        96'({32'h104, 4'b0011, 32'h0000DEAD}));
    do_access(1'b1, 3'b001, 32'h101, 32'h0000ABCD, 0, "sh_101");
    chk("sh_101_tx", 96'({tx_log[0].be, tx_log[0].wdata}), 96'({4'b0110, 32'h00ABCD00}));

    do_access(1'b0, 3'b011, 32'h100, 32'h0, 0, "f3_011");
    chk("f3_011_err", 96'(last_err), 96'(1));
    do_access(1'b1, 3'b100, 32'h100, 32'h55, 0, "sb_as_bu");
    chk("sb_as_bu_err", 96'(last_err), 96'(1));
    strict_err(3'b010, 32'h101, "strict_lw_101");
    strict_err(3'b001, 32'h103, "strict_lh_103");

    do_access(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, "lw_wrap");
    do_access(1'b1, 3'b001, 32'hFFFFFFFF, 32'h1234, 0, "sh_wrap");

    for (int it = 0; it < 150; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = (($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)));
      if (!we && $urandom_range(0, 3) == 0) f3 = 3'b100 | 3'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                          : 32'h100 + 32'($urandom_range(0, 31));
      do_access(we, f3, addr, $urandom, $urandom_range(0, 2), "rand");
    end

    // reset asserted while the second half of a split load is outstanding
    tx_log.delete();
    stall_cycles = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h103;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (tx_log.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_tx2", 96'(tx_log.size()), 96'(2));
    @(negedge clk);
    chk("mid_rst_in_wait2", 96'(dbg_state), 96'(WAIT2));
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    chk_reset("mid_rst_hold");
    rst_n = 1'b1;
    rv_pend = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 96'({resp_valid, req_ready}), 96'(2'b01));
    end
    do_access(1'b0, 3'b000, 32'h104, 32'h0, 0, "lb_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MISALIGN_EN, default 1; 1 = split misaligned accesses into two word transactions, 0 = flag them as errors.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, the core presents an access.
REQ-005 SHALL have port req_ready, output, 1, the unit accepts the access; transfer occurs when req_valid && req_ready.
REQ-006 SHALL have ports req_we (input, 1, store=1), req_funct3 (input, 3, RISC-V width code), req_addr (input, 32, byte address) and req_wdata (input, 32, store data, LSB-aligned).
REQ-007 SHALL have ports resp_valid (output, 1, one-cycle completion pulse), resp_rdata (output, 32, extended load data) and resp_err (output, 1, illegal or disallowed access).
REQ-008 SHALL have ports mem_valid (output, 1), mem_ready (input, 1), mem_we (output, 1), mem_addr (output, 32, word-aligned, bits[1:0]=00), mem_byteen (output, 4) and mem_wdata (output, 32, lane-positioned).
REQ-009 SHALL have ports mem_rvalid (input, 1, response/ack for each accepted transaction, loads and stores alike) and mem_rdata (input, 32).

Function
REQ-010 SHALL decode funct3 as: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only); any other code, and BU/HU with req_we=1, SHALL be illegal.
REQ-011 SHALL use FSM states IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
REQ-012 SHALL assert req_ready only in IDLE; on acceptance it latches all request fields.
REQ-013 SHALL, for an illegal access, or a misaligned one with MISALIGN_EN=0, go IDLE->RESP with no mem_valid, then assert resp_err=1 and resp_rdata=0.
REQ-014 SHALL treat an access as misaligned when (H and addr[1:0]=11) or (W and addr[1:0]!=00); B never misaligns.
REQ-015 SHALL, in REQ1, drive mem_valid=1, mem_addr={addr[31:2],00} and byteen = size mask (B 0001, H 0011, W 1111) shifted left by addr[1:0] and truncated to 4 bits; it holds all mem_* outputs stable until mem_ready.
REQ-016 SHALL drive mem_wdata = req_wdata << (8*addr[1:0]) in REQ1; in REQ2 it SHALL drive mem_wdata = req_wdata >> (8*(4-addr[1:0])).
REQ-017 SHALL go REQ1->WAIT1 on mem_ready; on mem_rvalid in WAIT1 it SHALL go to REQ2 if the access is split, else to RESP.
REQ-018 SHALL, in REQ2, drive mem_addr = first word address + 4 (wraps modulo 2^32) and byteen = high overflow bits of the shifted mask; WAIT2 exits to RESP on mem_rvalid.
REQ-019 SHALL capture mem_rdata at each mem_rvalid, form the 64-bit concatenation {second, first}, shift it right by 8*addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU, W) into resp_rdata.
REQ-020 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; stores SHALL return resp_rdata=0.
REQ-021 SHALL give an aligned-access latency of 2 cycles plus memory wait from acceptance to resp_valid, and ignore mem_rvalid outside WAIT1/WAIT2.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, req_ready=1, mem_valid=0, mem_we=0, mem_byteen=0000, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0 and resp_rdata=0.
REQ-023 SHALL abandon any in-flight transaction when reset asserts mid-operation, issue no response for it, and ignore any late mem_rvalid after reset.

Structure
REQ-024 SHALL take the funct3 width codes, the state enum type and the byte-mask constants from the shared package lsu_pkg.
REQ-025 SHALL implement load alignment/extension as the combinational sub-module lsu_load_align (inputs funct3, offset, 64-bit data; output 32-bit result).

Verification (mem[0x100]=0x7FFFFF7F, mem[0x104]=0x11223344, one-cycle mem_ready/mem_rvalid)
REQ-026 SHALL check: LB 0x100 -> one transaction with byteen 0001 and resp_rdata 0x0000007F; LH 0x100 -> 0xFFFFFF7F; LHU 0x100 -> 0x0000FF7F; LH 0x102 -> 0x00007FFF.
REQ-027 SHALL check: LW 0x103 -> reads 0x100/1000 then 0x104/0111, and resp_rdata 0x2233447F.
REQ-028 SHALL check: SW 0x102 data 0xDEADBEEF -> writes 0x100/1100/0xBEEF0000 then 0x104/0011/0x0000DEAD; SH 0x101 data 0xABCD -> byteen 0110 and wdata 0x00ABCD00.
REQ-029 SHALL check: funct3=011, or SB issued as BU -> resp_err=1 one cycle after acceptance, and mem_valid never rises; with MISALIGN_EN=0, LW 0x101 -> resp_err=1.
REQ-030 SHALL check: mem_ready held low for 5 cycles -> mem_* outputs stay stable throughout.
REQ-031 SHALL check: rst_n pulsed low during WAIT2 -> outputs match reset values, no resp_valid occurs, and the next LB completes normally.
